// File: rtl/l2_cache_control_if.sv
// Bundles the arbiter handshake, L2 datapath status/strobes and physical memory
// request lines seen by the L2 cache controller.
interface l2_cache_control_if;
  // Arbiter side
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic out_way_sel;
  // Datapath status
  logic hit0;
  logic hit1;
  logic dirty0;
  logic dirty1;
  logic lru;
  // Datapath strobes
  logic load_way0;
  logic load_way1;
  logic data_sel;
  logic set_dirty;
  logic clear_dirty;
  logic load_lru;
  logic lru_in;
  // Physical memory
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;
  logic pmem_addr_sel;

  modport master (
    input  mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp,
    output mem_resp, out_way_sel, load_way0, load_way1, data_sel, set_dirty,
           clear_dirty, load_lru, lru_in, pmem_read, pmem_write, pmem_addr_sel
  );

  modport slave (
    output mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp,
    input  mem_resp, out_way_sel, load_way0, load_way1, data_sel, set_dirty,
           clear_dirty, load_lru, lru_in, pmem_read, pmem_write, pmem_addr_sel
  );
endinterface

// File: rtl/l2_cache_control.sv
// Control FSM for a 2-way set-associative write-back L2: same-cycle hits,
// writeback/fetch on misses, plus saturating hit/miss counters.
module l2_cache_control #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  l2_cache_control_if.master   bus,
  input  logic                 clr_counts,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic                   refill_q, refill_d;
  logic [CNT_WIDTH-1:0]   hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0]   miss_count_q, miss_count_d;

  logic req, is_write, hit, hw, victim_dirty;
  logic count_hit, count_miss;

  // A simultaneous read and write is handled as a read.
  assign req          = bus.mem_read | bus.mem_write;
  assign is_write     = bus.mem_write & ~bus.mem_read;
  assign hit          = bus.hit0 | bus.hit1;
  assign hw           = ~bus.hit0;
  assign victim_dirty = bus.lru ? bus.dirty1 : bus.dirty0;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d           = state_q;
    refill_d          = refill_q;
    count_hit         = 1'b0;
    count_miss        = 1'b0;
    bus.mem_resp      = 1'b0;
    bus.out_way_sel   = 1'b0;
    bus.load_way0     = 1'b0;
    bus.load_way1     = 1'b0;
    bus.data_sel      = 1'b0;
    bus.set_dirty     = 1'b0;
    bus.clear_dirty   = 1'b0;
    bus.load_lru      = 1'b0;
    bus.lru_in        = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            count_hit       = ~refill_q;
            bus.mem_resp    = 1'b1;
            bus.load_lru    = 1'b1;
            bus.lru_in      = ~hw;
            bus.out_way_sel = hw;
            if (is_write) begin
              bus.load_way0 = ~hw;
              bus.load_way1 = hw;
              bus.data_sel  = 1'b1;
              bus.set_dirty = 1'b1;
            end
            refill_d = 1'b0;
          end else begin
            count_miss = ~refill_q;
            if (victim_dirty) begin
              state_d = WRITEBACK;
            end else if (is_write) begin
              // Write-allocate: the full line comes from the arbiter, no fetch.
              bus.load_way0 = ~bus.lru;
              bus.load_way1 = bus.lru;
              bus.data_sel  = 1'b1;
              bus.set_dirty = 1'b1;
              bus.load_lru  = 1'b1;
              bus.lru_in    = ~bus.lru;
              bus.mem_resp  = 1'b1;
              refill_d      = 1'b0;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) begin
          bus.clear_dirty = 1'b1;
          refill_d        = 1'b1;
          state_d         = IDLE;
        end
      end
      FETCH: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.load_way0   = ~bus.lru;
          bus.load_way1   = bus.lru;
          bus.clear_dirty = 1'b1;
          refill_d        = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (clr_counts) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else begin
      if (count_hit && hit_count_q != '1)   hit_count_d  = hit_count_q + CNT_ONE;
      if (count_miss && miss_count_q != '1) miss_count_d = miss_count_q + CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      refill_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      refill_q     <= refill_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed self-checking bench for l2_cache_control; counters use a 2-bit
// width so saturation is reachable in a few requests.
module tb_l2_cache_control;

  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst;
  logic          clr_counts;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  int checks = 0;
  int errors = 0;

  l2_cache_control_if bus ();

  l2_cache_control #(.CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_counts (clr_counts),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit0      = 1'b0;
    bus.hit1      = 1'b0;
    bus.dirty0    = 1'b0;
    bus.dirty1    = 1'b0;
    bus.lru       = 1'b0;
    bus.pmem_resp = 1'b0;
    clr_counts    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  int pr_cycles;

  initial begin
    rst = 1'b0;
    clear_inputs();
    apply_reset();

    // Idle after reset
    @(negedge clk);
    check("idle_mem_resp", bus.mem_resp, 1'b0);
    check("idle_pmem_read", bus.pmem_read, 1'b0);
    check("idle_pmem_write", bus.pmem_write, 1'b0);
    check("idle_load_lru", bus.load_lru, 1'b0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);

    // Read hit on way 1
    step();
    bus.mem_read = 1'b1; bus.hit1 = 1'b1; bus.lru = 1'b1;
    @(negedge clk);
    check("rh_mem_resp", bus.mem_resp, 1'b1);
    check("rh_out_way_sel", bus.out_way_sel, 1'b1);
    check("rh_load_lru", bus.load_lru, 1'b1);
    check("rh_lru_in", bus.lru_in, 1'b0);
    check("rh_load_way1", bus.load_way1, 1'b0);
    step();
    clear_inputs();
    check("rh_hit_count", hit_count, 1);
    check("rh_miss_count", miss_count, 0);

    // Clean read miss, pmem_resp on the third FETCH cycle
    apply_reset();
    bus.mem_read = 1'b1; bus.lru = 1'b0;
    @(negedge clk);
    check("crm_idle_resp", bus.mem_resp, 1'b0);
    check("crm_idle_pread", bus.pmem_read, 1'b0);
    step();
    pr_cycles = 0;
    for (int c = 0; c < 3; c++) begin
      bus.pmem_resp = (c == 2);
      @(negedge clk);
      if (bus.pmem_read) pr_cycles++;
      check("crm_addr_sel", bus.pmem_addr_sel, 1'b0);
      check("crm_mem_resp", bus.mem_resp, 1'b0);
      check("crm_load_way0", bus.load_way0, (c == 2));
      if (c == 2) begin
        check("crm_data_sel", bus.data_sel, 1'b0);
        check("crm_clear_dirty", bus.clear_dirty, 1'b1);
      end
      step();
    end
    check("crm_pread_cycles", pr_cycles, 3);
    bus.pmem_resp = 1'b0; bus.hit0 = 1'b1;
    @(negedge clk);
    check("crm_pread_after", bus.pmem_read, 1'b0);
    check("crm_resp", bus.mem_resp, 1'b1);
    check("crm_out_way_sel", bus.out_way_sel, 1'b0);
    check("crm_lru_in", bus.lru_in, 1'b1);
    step();
    clear_inputs();
    check("crm_miss_count", miss_count, 1);
    check("crm_hit_count", hit_count, 0);

    // Dirty write miss on way 1
    apply_reset();
    bus.mem_write = 1'b1; bus.lru = 1'b1; bus.dirty1 = 1'b1;
    @(negedge clk);
    check("dwm_idle_resp", bus.mem_resp, 1'b0);
    check("dwm_idle_load", bus.load_way1, 1'b0);
    step();
    @(negedge clk);
    check("dwm_pwrite", bus.pmem_write, 1'b1);
    check("dwm_pread", bus.pmem_read, 1'b0);
    check("dwm_addr_sel", bus.pmem_addr_sel, 1'b1);
    check("dwm_wb_clear_early", bus.clear_dirty, 1'b0);
    bus.pmem_resp = 1'b1;
    #1;
    check("dwm_clear_dirty", bus.clear_dirty, 1'b1);
    check("dwm_wb_resp", bus.mem_resp, 1'b0);
    step();
    bus.pmem_resp = 1'b0; bus.dirty1 = 1'b0;
    @(negedge clk);
    check("dwm_pwrite_after", bus.pmem_write, 1'b0);
    check("dwm_load_way1", bus.load_way1, 1'b1);
    check("dwm_load_way0", bus.load_way0, 1'b0);
    check("dwm_data_sel", bus.data_sel, 1'b1);
    check("dwm_set_dirty", bus.set_dirty, 1'b1);
    check("dwm_mem_resp", bus.mem_resp, 1'b1);
    check("dwm_load_lru", bus.load_lru, 1'b1);
    check("dwm_lru_in", bus.lru_in, 1'b0);
    step();
    clear_inputs();
    check("dwm_miss_count", miss_count, 1);
    check("dwm_hit_count", hit_count, 0);

    // Dual hit with a write: way 0 wins
    apply_reset();
    bus.mem_write = 1'b1; bus.hit0 = 1'b1; bus.hit1 = 1'b1; bus.lru = 1'b0;
    @(negedge clk);
    check("dh_load_way0", bus.load_way0, 1'b1);
    check("dh_load_way1", bus.load_way1, 1'b0);
    check("dh_lru_in", bus.lru_in, 1'b1);
    check("dh_set_dirty", bus.set_dirty, 1'b1);
    check("dh_data_sel", bus.data_sel, 1'b1);
    check("dh_mem_resp", bus.mem_resp, 1'b1);
    step();
    clear_inputs();

    // Read and write together on a clean miss behaves as a read: FETCH
    apply_reset();
    bus.mem_read = 1'b1; bus.mem_write = 1'b1;
    @(negedge clk);
    check("rw_no_alloc", bus.load_way0, 1'b0);
    check("rw_no_resp", bus.mem_resp, 1'b0);
    step();
    @(negedge clk);
    check("rw_fetch_pread", bus.pmem_read, 1'b1);
    check("rw_fetch_pwrite", bus.pmem_write, 1'b0);

    // Asynchronous reset in the middle of FETCH
    rst = 1'b1;
    #1;
    check("arst_pread", bus.pmem_read, 1'b0);
    check("arst_miss_count", miss_count, 0);
    clear_inputs();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle_pread", bus.pmem_read, 1'b0);
    check("arst_hit_count", hit_count, 0);
    step();

    // Saturation: five hits on a 2-bit counter, then clear alongside a hit
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      bus.mem_read = 1'b1; bus.hit0 = 1'b1;
      step();
      clear_inputs();
      step();
    end
    check("sat_hit_count", hit_count, 3);
    check("sat_miss_count", miss_count, 0);
    bus.mem_read = 1'b1; bus.hit0 = 1'b1; clr_counts = 1'b1;
    step();
    clear_inputs();
    check("clr_hit_count", hit_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/l2_cache_control.md
# l2_cache_control

Control FSM for the unified 2-way set-associative, write-back L2 cache that sits directly downstream of the I/D-cache arbiter. It accepts line-sized read and write requests from the arbiter, resolves hits in the same cycle, and fetches and writes back lines to physical memory on misses. It drives all load and select strobes of the L2 datapath, which owns the tag, valid, dirty, LRU and data arrays and reports per-set status back. It also keeps saturating hit and miss counters for performance analysis.

## Interface
- CNT_WIDTH, 16, width of the hit and miss counters
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  line read request from the arbiter; held until mem_resp
- mem_write  in  1  128-bit line write request from the arbiter; held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to the arbiter
- hit0, hit1  in  1  way 0/1 is valid and its tag matches the current address
- dirty0, dirty1  in  1  dirty bit of way 0/1 in the indexed set
- lru  in  1  LRU way of the indexed set; this way is the victim
- pmem_read, pmem_write  out  1  physical memory request; held until pmem_resp
- pmem_resp  in  1  physical memory completion pulse
- pmem_addr_sel  out  1  0: request address; 1: victim tag + index (writeback)
- load_way0, load_way1  out  1  write data, tag and valid=1 into way 0/1
- data_sel  out  1  line source: 0 = pmem fill, 1 = arbiter write data
- set_dirty, clear_dirty  out  1  applied to the way being loaded or written back
- load_lru  out  1  write lru_in into the indexed set
- lru_in  out  1  new LRU value
- out_way_sel  out  1  read-data mux to the arbiter: 1 selects way 1
- clr_counts  in  1  synchronous clear of both counters
- hit_count, miss_count  out  CNT_WIDTH  saturating counters

## Operation
- States: IDLE, WRITEBACK, FETCH. Internal flag `refill` marks a pending post-miss re-check.
- All outputs default to 0. All outputs except the counters are combinational from the state and the inputs.
- Define hit = hit0 | hit1 and hw = the hit way. If hit0 and hit1 are both set, way 0 wins.

**IDLE with a request and hit:**
- Assert mem_resp, load_lru, and lru_in = ~hw.
- out_way_sel = hw.
- On a write, also assert load_way[hw], data_sel=1, and set_dirty.
- Stay in IDLE and clear `refill`.

**IDLE with a request and miss, where the victim (way lru) is dirty:**
- Next state is WRITEBACK. No strobes are asserted.

**IDLE with a write request and miss, where the victim is clean (write-allocate, no fetch):**
- Assert load_way[lru], data_sel=1, set_dirty, load_lru, lru_in = ~lru, and mem_resp.
- Stay in IDLE.

**IDLE with a read request and miss, where the victim is clean:**
- Next state is FETCH.

**WRITEBACK:**
- Assert pmem_write and pmem_addr_sel=1.
- On pmem_resp: assert clear_dirty on way lru, set `refill`, go to IDLE.

**FETCH:**
- Assert pmem_read and pmem_addr_sel=0.
- On pmem_resp: assert load_way[lru], data_sel=0, clear_dirty; set `refill`; go to IDLE.
- The following IDLE cycle re-checks, hits, and responds.

**Requests during WRITEBACK/FETCH:**
- Request inputs are ignored. The pmem transaction always completes.

**If mem_read and mem_write are both asserted:**
- The request is treated as a read.

**Counters:**
- miss_count increments on each IDLE cycle that has a request, a miss, and `refill`=0.
- hit_count increments on each IDLE hit with `refill`=0.
- Neither counter changes on a hit with `refill`=1.
- Both counters saturate at all-ones.
- clr_counts takes priority over any increment in the same cycle.

## Timing
- Reset values: state IDLE, `refill`=0, hit_count=0, miss_count=0. With no request, all combinational outputs are 0.
- Reset mid-transaction: pmem_read and pmem_write deassert asynchronously. The datapath and pmem are not otherwise notified.
- Latencies, counted from the first request cycle:
  - Hit: mem_resp in the same cycle (0 wait).
  - Clean write miss: mem_resp in the same cycle.
  - Clean read miss: FETCH starts at cycle 1. With pmem_resp in cycle N, mem_resp arrives in cycle N+1.
  - Dirty read miss: WRITEBACK, then IDLE (re-check, victim now clean), then FETCH, then IDLE (hit).
  - Dirty write miss: WRITEBACK, then IDLE (clean write-allocate, mem_resp).
- mem_resp is never asserted outside IDLE and is never high for two consecutive cycles on the same request. The arbiter drops its request in the cycle after mem_resp.
- pmem_read and pmem_write are mutually exclusive and stay stable until pmem_resp.

## Test plan
- Reset: rst=1 during an active FETCH -> pmem_read=0 immediately; after release, state IDLE, both counters 0.
- Read hit: mem_read=1, hit1=1, lru=1 -> same cycle mem_resp=1, out_way_sel=1, load_lru=1, lru_in=0; hit_count=1.
- Clean read miss: mem_read=1, hit=0, lru=0, dirty0=0; pmem_resp on 3rd FETCH cycle -> pmem_read high 3 cycles, load_way0=1 and data_sel=0 on the resp cycle; next cycle hit0=1 gives mem_resp; miss_count=1, hit_count=0.
- Dirty write miss: mem_write=1, hit=0, lru=1, dirty1=1 -> WRITEBACK with pmem_write=1, pmem_addr_sel=1; on resp clear_dirty=1; next IDLE cycle (dirty1=0) load_way1=1, data_sel=1, set_dirty=1, mem_resp=1, lru_in=0; miss_count=1.
- Dual hit plus write: mem_write=1, hit0=hit1=1 -> load_way0 only, lru_in=1.
- Saturation and clear: CNT_WIDTH=2, 5 hits -> hit_count=3; clr_counts concurrent with a hit -> hit_count=0.
